afc_band_dco: RTL
=================

# afc_band_dco

Digital band-select oscillator emulator that closes the loop around the automatic frequency calibrator. It consumes the calibrator's 6-bit capacitor-bank code and synthesises the divided VCO clock `fdiv` whose period is a deterministic function of that code. It is clocked by the fast prescaler clock `fpre`, so the calibrator sees a frequency response to its own decisions. Code changes take effect only at period boundaries and are followed by a settling blank.

## Interface
- `CODE_W`, 6: width of band code.
- `BASE_HALF`, 8: `fdiv` half-period in `fpre` cycles at code 0; must be ≥ 2.
- `STEP_HALF`, 1: extra half-period cycles per code LSB (higher code = more capacitance = lower frequency).
- `SETTLE_CYC`, 16: blanking length after a code change or reset; must be ≥ 1.
- `RESET_CODE`, 32: band code loaded by reset (binary-search midpoint).

- `fpre`  in  1  block clock; all logic on rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `code_in`  in  CODE_W  band code from calibrator, synchronous to `fpre`.
- `fdiv`  out  1  synthesised divided clock, registered.
- `settled`  out  1  high when oscillating on the current code.
- `cur_code`  out  CODE_W  code currently applied.
- `period_cnt`  out  16  completed `fdiv` periods since last code application, saturating at 0xFFFF.

## Operation
- `HALF = BASE_HALF + cur_code*STEP_HALF`, computed in 16 bits; `BASE_HALF + (2^CODE_W−1)*STEP_HALF` must be < 2^16.
- Input filter: `code_in` is registered each cycle; `pending` is updated only when two consecutive samples match. One-cycle glitches never reach `pending`.
- FSM states: SETTLE, LOW, HIGH. A single down-counter `hcnt` is loaded on entry to each state.
  - SETTLE: `fdiv=0`, `settled=0`, lasts `SETTLE_CYC` cycles, then enters LOW.
  - LOW: `fdiv=0`, lasts `HALF` cycles, then enters HIGH. The rising edge of `fdiv` is the LOW→HIGH transition.
  - HIGH: `fdiv=1`, lasts `HALF` cycles. At the end of HIGH (period boundary):
    - `period_cnt` increments (saturating).
    - If `pending != cur_code`: `cur_code <= pending`, `period_cnt <= 0`, enter SETTLE.
    - Otherwise: enter LOW.
- `HALF` is evaluated at LOW/HIGH entry using the current `cur_code`.
- Code changes during SETTLE or mid-period update `pending` only. They are applied at the next period boundary. SETTLE always exits to LOW.
- If `pending` toggles back to `cur_code` before the boundary, no change is applied and no SETTLE occurs.

## Timing
- Reset (any cycle, mid-operation included) takes effect at the next edge:
  - `fdiv=0`, `settled=0`, `cur_code=RESET_CODE`, `pending=RESET_CODE`, `period_cnt=0`.
  - FSM enters SETTLE with `hcnt=SETTLE_CYC`; the LFSR is reseeded.
- After the first edge with `clr=0`:
  - `settled` rises after `SETTLE_CYC` cycles.
  - First `fdiv` rise occurs `SETTLE_CYC + HALF` cycles after that edge.
- Steady state: `fdiv` period is exactly `2*HALF` cycles, 50% duty.
- Code-to-application latency: 2 cycles of filter, plus wait to the next period boundary.
- `cur_code`, `settled` and `period_cnt` update on the same edge as the corresponding state transition.

## Configuration
- `AFC_DCO_JITTER_EN` defined:
  - 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 0xA5) advances at every LOW/HIGH entry.
  - Its two LSBs perturb that half-period: 00 → `HALF−1`, 11 → `HALF+1`, otherwise `HALF`.
  - SETTLE is unaffected.
- Undefined: no LFSR is present and half-periods are exactly `HALF`.

## Test plan
Defaults apply to all scenarios, so `HALF=40` and the period is 80 cycles at code 32.
- Reset release with `code_in=32` → `settled` rises after 16 cycles; first `fdiv` rise at cycle 56; thereafter rises every 80 cycles; `period_cnt` counts 1, 2, 3….
- `code_in` 32→0 in mid-HIGH → `cur_code` stays 32 until that period ends, then 0, with `period_cnt=0`, `settled=0` for 16 cycles; then period is 16 cycles.
- One-cycle pulse of `code_in=5` → `cur_code` and `fdiv` timing unchanged; no SETTLE.
- `code_in=63` → `HALF=71`, period 142 cycles; `period_cnt` increments once per period and is forced to saturate at 0xFFFF.
- `clr` asserted during HIGH at code 0 → next edge `fdiv=0`, `cur_code=32`, `period_cnt=0`, `settled=0`; restart timing matches the first scenario.
- With `AFC_DCO_JITTER_EN`, code 32 → every half-period lies in 39..41 and the sequence matches the LFSR model from seed 0xA5; without the macro, every half-period is exactly 40.

Source files
------------

// File: rtl/afc_band_dco.sv
// afc_band_dco: band-select DCO emulator that turns the AFC capacitor-bank code into the divided clock fdiv.
// Optional half-period jitter (8-bit LFSR) is built when AFC_DCO_JITTER_EN is defined.
module afc_band_dco #(
   parameter int CODE_W     = 6,
   parameter int BASE_HALF  = 8,
   parameter int STEP_HALF  = 1,
   parameter int SETTLE_CYC = 16,
   parameter int RESET_CODE = 32
) (
   input  logic              fpre,
   input  logic              clr,
   input  logic [CODE_W-1:0] code_in,
   output logic              fdiv,
   output logic              settled,
   output logic [CODE_W-1:0] cur_code,
   output logic [15:0]       period_cnt
);

   typedef enum logic [1:0] {
      ST_SETTLE,
      ST_LOW,
      ST_HIGH
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [15:0]       hcnt;
   logic [15:0]       hcnt_load;
   logic [15:0]       half_base;
   logic [15:0]       half_len;
   logic [CODE_W-1:0] code_s1;
   logic [CODE_W-1:0] pending;
   logic              hcnt_zero;
   logic              boundary;
   logic              code_change;
   logic              fdiv_d;
   logic              settled_d;

   assign hcnt_zero   = (hcnt == 16'd0);
   assign boundary    = (state == ST_HIGH) && hcnt_zero;
   assign code_change = (pending != cur_code);
   assign half_base   = 16'(BASE_HALF) + 16'(cur_code) * 16'(STEP_HALF);

   // Two matching consecutive samples are required before a code is accepted,
   // so single-cycle glitches from the calibrator never reach pending.
   always_ff @(posedge fpre) begin
      if (clr) begin
         code_s1 <= CODE_W'(RESET_CODE);
         pending <= CODE_W'(RESET_CODE);
      end else begin
         code_s1 <= code_in;
         if (code_in == code_s1) begin
            pending <= code_in;
         end
      end
   end

`ifdef AFC_DCO_JITTER_EN
   logic [7:0] lfsr;
   logic [7:0] lfsr_nxt;

   assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

   // The LFSR steps once per LOW/HIGH entry; the freshly stepped value shapes that half-period.
   always_ff @(posedge fpre) begin
      if (clr) begin
         lfsr <= 8'hA5;
      end else if (hcnt_zero && (state_nxt != ST_SETTLE)) begin
         lfsr <= lfsr_nxt;
      end
   end

   always_comb begin
      half_len = half_base;
      case (lfsr_nxt[1:0])
         2'b00:   half_len = half_base - 16'd1;
         2'b11:   half_len = half_base + 16'd1;
         default: half_len = half_base;
      endcase
   end
`else
   assign half_len = half_base;
`endif

   always_comb begin
      hcnt_load = 16'(SETTLE_CYC - 1);
      if (state_nxt != ST_SETTLE) begin
         hcnt_load = half_len - 16'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_SETTLE: if (hcnt_zero) state_nxt = ST_LOW;
         ST_LOW:    if (hcnt_zero) state_nxt = ST_HIGH;
         ST_HIGH:   if (hcnt_zero) state_nxt = code_change ? ST_SETTLE : ST_LOW;
         default:   state_nxt = ST_SETTLE;
      endcase
   end

   // Outputs are decoded from the next state and then registered, keeping fdiv glitch-free.
   always_comb begin
      fdiv_d    = (state_nxt == ST_HIGH);
      settled_d = (state_nxt != ST_SETTLE);
   end

   // Reset loads the full settle count because the reset edge itself is not a settling
   // cycle; every later entry loads length-1 and leaves the state when hcnt reaches zero.
   always_ff @(posedge fpre) begin
      if (clr) begin
         state   <= ST_SETTLE;
         hcnt    <= 16'(SETTLE_CYC);
         fdiv    <= 1'b0;
         settled <= 1'b0;
      end else begin
         state   <= state_nxt;
         hcnt    <= hcnt_zero ? hcnt_load : hcnt - 16'd1;
         fdiv    <= fdiv_d;
         settled <= settled_d;
      end
   end

   always_ff @(posedge fpre) begin
      if (clr) begin
         cur_code   <= CODE_W'(RESET_CODE);
         period_cnt <= 16'd0;
      end else if (boundary) begin
         if (code_change) begin
            cur_code   <= pending;
            period_cnt <= 16'd0;
         end else if (period_cnt != 16'hFFFF) begin
            period_cnt <= period_cnt + 16'd1;
         end
      end
   end

endmodule
